// File: rtl/aes_tx_block_sequencer.sv
// aes_tx_block_sequencer: takes one cipher block over a valid/ready handshake
// and feeds it MSB-first, one byte per tx_drive, to a UART transmitter. Each
// byte waits for the transmitter's tx_done, then an optional GAP_CYCLES pause.
// Optional feature macro: AES_TX_SEQ_FRAME_EN wraps every block as
// 0xA5 header, data bytes, XOR checksum byte.
module aes_tx_block_sequencer #(
  parameter int NUM_BYTES  = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   block_valid,
  input  logic [8*NUM_BYTES-1:0] block_data,
  output logic                   block_ready,
  output logic                   tx_drive,
  output logic [7:0]             tx_byte_out,
  input  logic                   tx_done,
  output logic                   busy,
  output logic                   block_sent
);

  localparam int BW = 8 * NUM_BYTES;
  localparam int IW = $clog2(NUM_BYTES + 2);
`ifdef AES_TX_SEQ_FRAME_EN
  localparam int LAST = NUM_BYTES + 1;
  localparam logic [IW-1:0] DATA_END = IW'(NUM_BYTES);
`else
  localparam int LAST = NUM_BYTES - 1;
`endif
  localparam logic [IW-1:0] LAST_IDX = IW'(LAST);
  localparam logic [7:0]    GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT_DONE, GAP, DONE} state_t;

  state_t          state, state_n;
  logic            ready_q;
  logic [IW-1:0]   idx, idx_n;
  logic [BW-1:0]   sreg, sreg_n;
  logic [7:0]      cnt, cnt_n;
  logic [7:0]      byte_q, byte_n;
  logic            shift_ok;

`ifdef AES_TX_SEQ_FRAME_EN
  logic [7:0] csum;
  logic       data_byte;

  // Header at index 0, data in 1..NUM_BYTES, checksum last. The shift
  // register only advances after a data byte so byte 0 is still on top
  // when index 1 is driven.
  assign shift_ok  = (idx != '0);
  assign data_byte = (idx_n != '0) && (idx_n <= DATA_END);
  assign byte_n    = (idx_n == '0) ? 8'hA5 :
                     data_byte     ? sreg_n[BW-1 -: 8] : csum;

  // Running XOR of data bytes, folded in as each one is launched.
  always_ff @(posedge clk) begin
    if (reset)                           csum <= '0;
    else if (state == IDLE)              csum <= '0;
    else if (state_n == DRIVE && data_byte) csum <= csum ^ byte_n;
  end
`else
  assign shift_ok = 1'b1;
  assign byte_n   = sreg_n[BW-1 -: 8];
`endif

  // Next-state and datapath updates; defaults hold everything.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    sreg_n  = sreg;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (block_valid && ready_q) begin
          sreg_n  = block_data;
          idx_n   = '0;
          state_n = DRIVE;
        end
      end
      DRIVE: state_n = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_done) begin
          if (idx == LAST_IDX) begin
            state_n = DONE;
          end else begin
            idx_n = idx + 1'b1;
            if (shift_ok) sreg_n = sreg << 8;
            cnt_n   = '0;
            state_n = (GAP_CYCLES == 0) ? DRIVE : GAP;
          end
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) state_n = DRIVE;
        else                 cnt_n   = cnt + 8'd1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; the output byte is captured only when a
  // DRIVE is entered so it stays stable across WAIT_DONE and GAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      idx     <= '0;
      sreg    <= '0;
      cnt     <= '0;
      byte_q  <= '0;
    end else begin
      state   <= state_n;
      ready_q <= (state_n == IDLE);
      idx     <= idx_n;
      sreg    <= sreg_n;
      cnt     <= cnt_n;
      if (state_n == DRIVE) byte_q <= byte_n;
    end
  end

  // ready is a separate flop so it reads 0 throughout reset even though
  // the state register already sits in IDLE.
  assign block_ready = ready_q;
  assign tx_drive    = (state == DRIVE);
  assign tx_byte_out = byte_q;
  assign busy        = (state != IDLE);
  assign block_sent  = (state == DONE);

endmodule

// File: tb/tb_aes_tx_block_sequencer.sv
// Bench for aes_tx_block_sequencer: two instances (GAP_CYCLES 0 and 3), a
// transmitter responder, and a byte scoreboard filled at each accept.
module tb_aes_tx_block_sequencer;

  localparam int NB = 16;
`ifdef AES_TX_SEQ_FRAME_EN
  localparam int TOT = NB + 2;
`else
  localparam int TOT = NB;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  logic rst_q = 1'b0, rst_q2 = 1'b0;

  logic            valid[2];
  logic [8*NB-1:0] data[2];
  logic            ready[2], drive[2], busy[2], sent[2], done[2];
  logic [7:0]      txb[2];
  logic            adone[2], spur_r[2], spur_tb[2], spur_en[2], arm[2];
  int              cd[2];

  logic [7:0] exp_q[2][$];
  int  last_done[2], acc_edge[2], nbytes[2], dcount[2], sent_cnt[2];
  bit  inflight[2], b2b_chk[2];
  int  n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    aes_tx_block_sequencer #(.NUM_BYTES(NB), .GAP_CYCLES(g == 0 ? 0 : 3)) u_dut (
      .clk(clk), .reset(reset), .block_valid(valid[g]), .block_data(data[g]),
      .block_ready(ready[g]), .tx_drive(drive[g]), .tx_byte_out(txb[g]),
      .tx_done(done[g]), .busy(busy[g]), .block_sent(sent[g]));
    assign done[g] = adone[g] | spur_r[g] | spur_tb[g];
  end

  function automatic int gapv(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic logic [7:0] byte_of(input logic [8*NB-1:0] d, input int k);
    logic [8*NB-1:0] s;
    s = d >> (8 * (NB - 1 - k));
    return s[7:0];
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Edge counter and sampled reset history.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rst_q  <= reset;
    rst_q2 <= rst_q;
  end

  // Transmitter model: tx_done five cycles after each drive, optionally
  // followed by a stray tx_done the next cycle.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      adone[i]  = 1'b0;
      spur_r[i] = 1'b0;
      if (reset) begin
        cd[i]  = 0;
        arm[i] = 1'b0;
      end else begin
        if (arm[i]) begin spur_r[i] = 1'b1; arm[i] = 1'b0; end
        if (cd[i] > 0) begin
          cd[i]--;
          if (cd[i] == 0) begin adone[i] = 1'b1; arm[i] = spur_en[i]; end
        end
        if (drive[i]) cd[i] = 5;
      end
    end
  end

  // Monitor / scoreboard. At a negedge, cyc is the last edge number and
  // current inputs will be sampled at edge cyc+1.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_q) begin
        exp_q[i].delete();
        inflight[i] = 1'b0;
        check("rst_ready", ready[i], 0);
        check("rst_drive", drive[i], 0);
        check("rst_byte",  txb[i],   0);
        check("rst_busy",  busy[i],  0);
        check("rst_sent",  sent[i],  0);
      end else begin
        if (rst_q2) check("ready_after_rst", ready[i], 1);
        if (!reset && adone[i]) begin
          last_done[i] = cyc + 1;
          dcount[i]++;
        end
        if (!reset && valid[i] && ready[i]) begin
          acc_edge[i] = cyc + 1;
          nbytes[i]   = 0;
          dcount[i]   = 0;
          if (b2b_chk[i]) check("b2b_accept_gap", acc_edge[i] - last_done[i], 2);
`ifdef AES_TX_SEQ_FRAME_EN
          begin
            logic [7:0] x;
            x = 8'h00;
            exp_q[i].push_back(8'hA5);
            for (int k = 0; k < NB; k++) begin
              exp_q[i].push_back(byte_of(data[i], k));
              x ^= byte_of(data[i], k);
            end
            exp_q[i].push_back(x);
          end
`else
          for (int k = 0; k < NB; k++) exp_q[i].push_back(byte_of(data[i], k));
`endif
        end
        if (drive[i]) begin
          if (exp_q[i].size() == 0) begin
            check("extra_drive", 1, 0);
          end else begin
            check("drive_byte", txb[i], exp_q[i].pop_front());
            if (nbytes[i] == 0) check("first_drive_lat", cyc, acc_edge[i]);
            else                check("done_to_drive_lat", cyc, last_done[i] + gapv(i));
            nbytes[i]++;
            inflight[i] = 1'b1;
          end
        end
        if (inflight[i]) begin
          check("busy_in_flight", busy[i], 1);
          check("ready_in_flight", ready[i], 0);
        end
        if (sent[i]) begin
          check("sent_nbytes", nbytes[i], TOT);
          check("sent_lat", cyc, last_done[i]);
          sent_cnt[i]++;
          inflight[i] = 1'b0;
        end
      end
    end
  end

  // Offer a block on instance i; returns one cycle after the accept edge.
  task automatic offer(input int i, input logic [8*NB-1:0] d, input bit b2b);
    int t;
    t = 0;
    b2b_chk[i] = b2b;
    valid[i]   = 1'b1;
    data[i]    = d;
    while (!ready[i] && t < 3000) begin @(posedge clk); #1; t++; end
    if (!ready[i]) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    valid[i]   = 1'b0;
    b2b_chk[i] = 1'b0;
    data[i]    = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_sent(input int i, input int n);
    int t;
    t = 0;
    while (sent_cnt[i] < n && t < 3000) begin @(posedge clk); #1; t++; end
    check("block_sent_count", sent_cnt[i], n);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0; data[i] = '0; spur_tb[i] = 1'b0; spur_en[i] = 1'b0;
      b2b_chk[i] = 1'b0; sent_cnt[i] = 0; nbytes[i] = 0; dcount[i] = 0;
      last_done[i] = 0; acc_edge[i] = 0; inflight[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single block, no gap.
    offer(0, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0);
    wait_sent(0, 1);
    repeat (3) @(posedge clk);
    #1;

    // Block B held valid while A is in flight.
    offer(0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
    offer(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
    wait_sent(0, 3);

    // Gap of 3 with stray tx_done in GAP/DONE, then one in IDLE.
    spur_en[1] = 1'b1;
    offer(1, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
    wait_sent(1, 1);
    spur_en[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 spur_tb[1] = 1'b1; spur_tb[0] = 1'b1;
    @(posedge clk);
    #1 spur_tb[1] = 1'b0; spur_tb[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Reset on the same edge that samples the 5th tx_done.
    offer(0, 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF, 1'b0);
    t = 0;
    while (!(adone[0] && dcount[0] == 4) && t < 500) begin
      @(posedge clk); #2; t++;
    end
    check("reset_point_found", dcount[0], 4);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("no_sent_after_abort", sent_cnt[0], 3);
    offer(0, 128'h5A5A5A5A_00000000_FFFFFFFF_C3C3C3C3, 1'b0);
    wait_sent(0, 4);

`ifdef AES_TX_SEQ_FRAME_EN
    offer(0, {16{8'h01}}, 1'b0);
    wait_sent(0, 5);
    offer(0, {8'h80, 120'h0}, 1'b0);
    wait_sent(0, 6);
`endif

    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_empty0", exp_q[0].size(), 0);
    check("scoreboard_empty1", exp_q[1].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not reach its end, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
